// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//
// Purpose:
//   Sequences the multi-cycle iterative divider for DIV/DIVU instructions held
//   in the EX stage. One request is issued per instruction; the pipeline is
//   stalled while the divide is in flight. Each completed divide produces a
//   single HI/LO write strobe. Divide-by-zero is resolved locally without
//   touching the divider, and results orphaned by a pipeline flush are drained
//   and thrown away.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   flush           pipeline flush/exception, kills the EX-stage divide
//   req_valid       EX stage holds a DIV/DIVU instruction
//   req_sign        1 = DIV (signed), 0 = DIVU
//   req_a, req_b    dividend / divisor
//   ex_advance      EX instruction moves to MEM this cycle
//   stall_ex        freeze IF/ID/EX (combinational)
//   div_valid       one-cycle request pulse to the divider (registered)
//   div_sign        latched operation sign
//   div_a, div_b    latched operands
//   div_res_valid   divider result available
//   div_res_ready   controller accepts the result
//   div_result      {remainder, quotient} from the divider
//   hilo_we         one-cycle HI/LO write strobe (registered)
//   hi_o, lo_o      values for HI and LO
//   div_timeout     sticky flag: divider exceeded TIMEOUT cycles
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic                  req_sign,
    input  logic [DATA_W-1:0]     req_a,
    input  logic [DATA_W-1:0]     req_b,
    input  logic                  ex_advance,
    output logic                  stall_ex,
    output logic                  div_valid,
    output logic                  div_sign,
    output logic [DATA_W-1:0]     div_a,
    output logic [DATA_W-1:0]     div_b,
    input  logic                  div_res_valid,
    output logic                  div_res_ready,
    input  logic [2*DATA_W-1:0]   div_result,
    output logic                  hilo_we,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  div_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    // The timeout flag is raised on the last counted cycle, so the compare
    // value is one below TIMEOUT; 2^CNT_W > TIMEOUT keeps it reachable
    // before the counter saturates.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e               state_q,     state_d;
    logic                 div_valid_q, div_valid_d;
    logic                 div_sign_q,  div_sign_d;
    logic [DATA_W-1:0]    div_a_q,     div_a_d;
    logic [DATA_W-1:0]    div_b_q,     div_b_d;
    logic                 hilo_we_q,   hilo_we_d;
    logic [DATA_W-1:0]    hi_q,        hi_d;
    logic [DATA_W-1:0]    lo_q,        lo_d;
    logic                 timeout_q,   timeout_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;

    logic                 req_zero;
    logic                 req_go;
    logic                 cnt_active;
    logic                 cnt_enter;

    assign req_zero = (req_b == '0);
    // A non-zero divide that the EX stage really owns this cycle.
    assign req_go   = req_valid & ~flush & ~req_zero;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d       = state_q;
        div_valid_d   = 1'b0;
        div_sign_d    = div_sign_q;
        div_a_d       = div_a_q;
        div_b_d       = div_b_q;
        hilo_we_d     = 1'b0;
        hi_d          = hi_q;
        lo_d          = lo_q;
        stall_ex      = 1'b0;
        div_res_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_ex = req_go;
                if (req_valid && !flush) begin
                    if (req_zero) begin
                        // Divide-by-zero: HI = dividend, LO = all ones,
                        // written the following cycle without a stall.
                        hi_d      = req_a;
                        lo_d      = '1;
                        hilo_we_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        div_a_d     = req_a;
                        div_b_d     = req_b;
                        div_sign_d  = req_sign;
                        div_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                // The request pulse is already on the wire this cycle, so a
                // flush here still leaves a result to drain.
                stall_ex = ~flush;
                state_d  = flush ? S_DRAIN : S_WAIT;
            end

            S_WAIT: begin
                stall_ex      = ~flush;
                div_res_ready = 1'b1;
                if (div_res_valid) begin
                    if (flush) begin
                        // Result accepted but belongs to a killed instruction.
                        state_d = S_IDLE;
                    end else begin
                        hi_d      = div_result[2*DATA_W-1:DATA_W];
                        lo_d      = div_result[DATA_W-1:0];
                        hilo_we_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end

            S_DONE: begin
                // The same instruction may still sit in EX; only its
                // departure (or a flush) re-arms the controller.
                if (ex_advance || flush) begin
                    state_d = S_IDLE;
                end
            end

            S_DRAIN: begin
                // A younger divide must wait until the stale result is gone.
                stall_ex      = req_valid;
                div_res_ready = 1'b1;
                if (div_res_valid) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Timeout supervision: counts cycles spent waiting on the divider.
    // -------------------------------------------------------------------------
    assign cnt_active = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign cnt_enter  = ((state_d == S_WAIT) || (state_d == S_DRAIN)) &&
                        (state_d != state_q);

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (cnt_active && (cnt_q == CNT_LAST)) begin
            timeout_d = 1'b1;
        end
        if (cnt_enter) begin
            cnt_d = '0;
        end else if (cnt_active && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_valid_q <= 1'b0;
            div_sign_q  <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            hilo_we_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            div_valid_q <= div_valid_d;
            div_sign_q  <= div_sign_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            hilo_we_q   <= hilo_we_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign div_valid   = div_valid_q;
    assign div_sign    = div_sign_q;
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign hilo_we     = hilo_we_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign div_timeout = timeout_q;

endmodule
